// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the CPU IO port to serial byte-stream bridge.
package io_bridge_pkg;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam int         STAT_ADDR_BIT = 2;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO; dout shows the head whenever the FIFO is not empty.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axi_io_serial_bridge.sv
// AXI4 byte-wide IO slave: write beats feed a one-deep TX buffer, reads return
// buffered RX bytes (araddr[2]=0) or a status byte (araddr[2]=1).
module axi_io_serial_bridge
    import io_bridge_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_io_awid,
    input  logic [ADDR_WIDTH-1:0] s_io_awaddr,
    input  logic [7:0]            s_io_awlen,
    input  logic                  s_io_awvalid,
    output logic                  s_io_awready,
    input  logic [7:0]            s_io_wdata,
    input  logic                  s_io_wlast,
    input  logic                  s_io_wvalid,
    output logic                  s_io_wready,
    output logic [ID_WIDTH-1:0]   s_io_bid,
    output logic [1:0]            s_io_bresp,
    output logic                  s_io_bvalid,
    input  logic                  s_io_bready,
    input  logic [ID_WIDTH-1:0]   s_io_arid,
    input  logic [ADDR_WIDTH-1:0] s_io_araddr,
    input  logic [7:0]            s_io_arlen,
    input  logic                  s_io_arvalid,
    output logic                  s_io_arready,
    output logic [ID_WIDTH-1:0]   s_io_rid,
    output logic [7:0]            s_io_rdata,
    output logic [1:0]            s_io_rresp,
    output logic                  s_io_rlast,
    output logic                  s_io_rvalid,
    input  logic                  s_io_rready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);
    localparam int CW = $clog2(RX_DEPTH + 1);

    wstate_t               wstate_q, wstate_d;
    rstate_t               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   bid_q, rid_q;
    logic                  stat_sel_q;
    logic [7:0]            rcnt_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  fifo_empty, fifo_full;
    logic [7:0]            fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic [7:0]            stat_byte;
    logic                  unused_inputs;

    assign unused_inputs = ^{s_io_awaddr, s_io_awlen,
                             s_io_araddr[ADDR_WIDTH-1:STAT_ADDR_BIT+1],
                             s_io_araddr[STAT_ADDR_BIT-1:0]};

    assign aw_hs = s_io_awvalid && s_io_awready;
    assign w_hs  = s_io_wvalid && s_io_wready;
    assign ar_hs = s_io_arvalid && s_io_arready;
    assign r_hs  = s_io_rvalid && s_io_rready;

    assign stat_byte = {6'(fifo_count), fifo_full, tx_valid_q};

    byte_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid && rx_ready),
        .din   (rx_data),
        .pop   (r_hs && !stat_sel_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            bid_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            if (aw_hs) bid_q <= s_io_awid;
            if (w_hs) begin
                tx_data_q  <= s_io_wdata;
                tx_valid_q <= 1'b1;
            end else if (tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && s_io_wlast) wstate_d = W_DRAIN;
            W_DRAIN: if (!tx_valid_q || tx_ready) wstate_d = W_RESP;
            W_RESP:  if (s_io_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_io_awready = 1'b0;
        s_io_wready  = 1'b0;
        s_io_bvalid  = 1'b0;
        if (!rst) begin
            case (wstate_q)
                W_IDLE:  s_io_awready = 1'b1;
                W_DATA:  s_io_wready  = !tx_valid_q || tx_ready;
                W_RESP:  s_io_bvalid  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q   <= R_IDLE;
            rid_q      <= '0;
            stat_sel_q <= 1'b0;
            rcnt_q     <= '0;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) begin
                rid_q      <= s_io_arid;
                stat_sel_q <= s_io_araddr[STAT_ADDR_BIT];
                rcnt_q     <= s_io_arlen;
            end else if (r_hs) begin
                rcnt_q <= rcnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && s_io_rlast) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Status beats are always valid; data beats wait for the FIFO with no timeout.
    always_comb begin
        s_io_arready = 1'b0;
        s_io_rvalid  = 1'b0;
        s_io_rdata   = '0;
        s_io_rlast   = 1'b0;
        if (!rst) begin
            case (rstate_q)
                R_IDLE: s_io_arready = 1'b1;
                R_DATA: begin
                    s_io_rvalid = stat_sel_q || !fifo_empty;
                    s_io_rdata  = stat_sel_q ? stat_byte : fifo_dout;
                    s_io_rlast  = (rcnt_q == 8'd0);
                end
                default: ;
            endcase
        end
    end

    assign s_io_bid   = bid_q;
    assign s_io_bresp = RESP_OKAY;
    assign s_io_rid   = rid_q;
    assign s_io_rresp = RESP_OKAY;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign rx_ready   = !rst && !fifo_full;

endmodule

// File: tb/tb_axi_io_serial_bridge.sv
// Directed and randomized checks of the IO bridge against a queue-based model.
module tb_axi_io_serial_bridge;
    localparam int IDW   = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] s_io_awid, s_io_arid, s_io_bid, s_io_rid;
    logic [AW-1:0]  s_io_awaddr, s_io_araddr;
    logic [7:0]     s_io_awlen, s_io_arlen, s_io_wdata, s_io_rdata;
    logic           s_io_awvalid, s_io_awready, s_io_wlast, s_io_wvalid, s_io_wready;
    logic [1:0]     s_io_bresp, s_io_rresp;
    logic           s_io_bvalid, s_io_bready, s_io_arvalid, s_io_arready;
    logic           s_io_rlast, s_io_rvalid, s_io_rready;
    logic [7:0]     tx_data, rx_data;
    logic           tx_valid, tx_ready, rx_valid, rx_ready;

    int  checks = 0;
    int  passes = 0;
    bit  tx_rand = 1'b0;
    logic [7:0] tx_seen[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    axi_io_serial_bridge #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_io_awid(s_io_awid), .s_io_awaddr(s_io_awaddr), .s_io_awlen(s_io_awlen),
        .s_io_awvalid(s_io_awvalid), .s_io_awready(s_io_awready),
        .s_io_wdata(s_io_wdata), .s_io_wlast(s_io_wlast), .s_io_wvalid(s_io_wvalid),
        .s_io_wready(s_io_wready),
        .s_io_bid(s_io_bid), .s_io_bresp(s_io_bresp), .s_io_bvalid(s_io_bvalid),
        .s_io_bready(s_io_bready),
        .s_io_arid(s_io_arid), .s_io_araddr(s_io_araddr), .s_io_arlen(s_io_arlen),
        .s_io_arvalid(s_io_arvalid), .s_io_arready(s_io_arready),
        .s_io_rid(s_io_rid), .s_io_rdata(s_io_rdata), .s_io_rresp(s_io_rresp),
        .s_io_rlast(s_io_rlast), .s_io_rvalid(s_io_rvalid), .s_io_rready(s_io_rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) tx_seen.push_back(tx_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_rand) tx_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({s_io_awready, s_io_wready, s_io_bid, s_io_bresp, s_io_bvalid,
                    s_io_arready, s_io_rid, s_io_rdata, s_io_rresp, s_io_rlast,
                    s_io_rvalid, tx_data, tx_valid, rx_ready});
    endfunction

    // Status byte with TX idle: count in [7:2], full flag in bit 1.
    function automatic logic [7:0] stat_exp();
        int c = rx_q.size();
        return 8'((c << 2) | ((c == DEPTH) ? 2 : 0));
    endfunction

    task automatic rx_push(input logic [7:0] b);
        bit exp_ready = (rx_q.size() < DEPTH);
        rx_data  = b;
        rx_valid = 1'b1;
        check("rx_ready", rx_ready, exp_ready);
        tick();
        rx_valid = 1'b0;
        if (exp_ready) rx_q.push_back(b);
    endtask

    task automatic write_burst(input logic [IDW-1:0] id, input int n, input bit rnd, input int stall);
        logic [7:0] exp_q[$];
        int guard;
        tx_seen.delete();
        tx_rand = rnd;
        if (!rnd) tx_ready = 1'b1;
        s_io_awid    = id;
        s_io_awlen   = 8'(n - 1);
        s_io_awaddr  = $urandom;
        s_io_awvalid = 1'b1;
        check("awready", s_io_awready, 1);
        tick();
        s_io_awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b = 8'($urandom);
            exp_q.push_back(b);
            s_io_wdata  = b;
            s_io_wlast  = (i == n - 1);
            s_io_wvalid = 1'b1;
            guard = 0;
            while (!s_io_wready && guard < 200) begin tick(); guard++; end
            check("w_timeout", guard < 200, 1);
            tick();
            if (i == 0 && stall > 0) begin
                tx_ready = 1'b0;
                #1;
                for (int k = 0; k < stall; k++) begin
                    check("wready_stall", s_io_wready, 0);
                    check("bvalid_stall", s_io_bvalid, 0);
                    tick();
                end
                tx_ready = 1'b1;
                #1;
            end
        end
        s_io_wvalid = 1'b0;
        s_io_wlast  = 1'b0;
        guard = 0;
        while (!s_io_bvalid && guard < 200) begin tick(); guard++; end
        check("b_timeout", guard < 200, 1);
        check("tx_count", tx_seen.size(), n);
        for (int i = 0; i < n && i < tx_seen.size(); i++) check("tx_byte", tx_seen[i], exp_q[i]);
        check("bid", s_io_bid, id);
        check("bresp", s_io_bresp, 0);
        s_io_bready = 1'b1;
        tick();
        s_io_bready = 1'b0;
        check("bvalid_clear", s_io_bvalid, 0);
        tx_rand  = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic read_burst(input logic [IDW-1:0] id, input bit stat, input int n);
        int guard;
        s_io_arid    = id;
        s_io_araddr  = $urandom;
        s_io_araddr[2] = stat;
        s_io_arlen   = 8'(n - 1);
        s_io_arvalid = 1'b1;
        s_io_rready  = 1'b1;
        check("arready", s_io_arready, 1);
        tick();
        s_io_arvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] exp_b;
            guard = 0;
            while (!s_io_rvalid && guard < 200) begin tick(); guard++; end
            check("r_timeout", guard < 200, 1);
            if (stat) exp_b = stat_exp();
            else if (rx_q.size() > 0) exp_b = rx_q.pop_front();
            else exp_b = 8'hxx;
            check(stat ? "rdata_stat" : "rdata", s_io_rdata, exp_b);
            check("rlast", s_io_rlast, (i == n - 1));
            check("rid", s_io_rid, id);
            check("rresp", s_io_rresp, 0);
            tick();
        end
        s_io_rready = 1'b0;
        check("arready_after", s_io_arready, 1);
    endtask

    initial begin
        rst = 1'b1;
        {s_io_awid, s_io_awaddr, s_io_awlen, s_io_awvalid} = '0;
        {s_io_wdata, s_io_wlast, s_io_wvalid, s_io_bready} = '0;
        {s_io_arid, s_io_araddr, s_io_arlen, s_io_arvalid, s_io_rready} = '0;
        {rx_data, rx_valid} = '0;
        tx_ready = 1'b1;
        tick();
        tick();
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        #1;
        check("post_rst_awready", s_io_awready, 1);
        check("post_rst_arready", s_io_arready, 1);
        check("post_rst_rx_ready", rx_ready, 1);

        // Exact-timing write burst: id 3, bytes 11/22/33, tx_ready held high.
        tx_seen.delete();
        s_io_awid = 3; s_io_awlen = 8'd2; s_io_awvalid = 1'b1;
        tick();
        s_io_awvalid = 1'b0;
        s_io_wdata = 8'h11; s_io_wvalid = 1'b1;
        check("wready_first", s_io_wready, 1);
        tick();
        check("tx_valid_1", tx_valid, 1);
        check("tx_data_1", tx_data, 8'h11);
        s_io_wdata = 8'h22;
        tick();
        check("tx_data_2", tx_data, 8'h22);
        s_io_wdata = 8'h33; s_io_wlast = 1'b1;
        tick();
        check("tx_data_3", tx_data, 8'h33);
        s_io_wvalid = 1'b0; s_io_wlast = 1'b0;
        check("bvalid_early", s_io_bvalid, 0);
        tick();
        check("bvalid_timed", s_io_bvalid, 1);
        check("bid_timed", s_io_bid, 3);
        check("bresp_timed", s_io_bresp, 0);
        check("tx_seen_timed", tx_seen.size(), 3);
        s_io_bready = 1'b1;
        tick();
        s_io_bready = 1'b0;

        // TX backpressure for 20 cycles after the first beat.
        write_burst(4'd6, 4, 1'b0, 20);

        // RX buffering up to full, fifth byte refused, then drained by one read.
        rx_push(8'h44); rx_push(8'h55); rx_push(8'h66); rx_push(8'h77);
        rx_push(8'h88);
        check("rx_full_status", rx_ready, 0);
        read_burst(4'd1, 1'b0, 4);
        check("rx_ready_back", rx_ready, 1);

        // Blocking read: rvalid waits for the byte, then appears the next cycle.
        s_io_arid = 4'd2; s_io_araddr = '0; s_io_arlen = 8'd0; s_io_arvalid = 1'b1; s_io_rready = 1'b1;
        tick();
        s_io_arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("rvalid_blocked", s_io_rvalid, 0);
            tick();
        end
        rx_data = 8'h5A; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("rvalid_unblock", s_io_rvalid, 1);
        check("rdata_unblock", s_io_rdata, 8'h5A);
        check("rlast_unblock", s_io_rlast, 1);
        tick();
        s_io_rready = 1'b0;
        check("rvalid_done", s_io_rvalid, 0);

        // Status read with two bytes buffered does not pop.
        rx_push(8'hA1); rx_push(8'hA2);
        read_burst(4'd7, 1'b1, 1);
        read_burst(4'd8, 1'b1, 3);
        read_burst(4'd9, 1'b0, 2);

        // Reset mid-write with three RX bytes buffered.
        tx_ready = 1'b0;
        s_io_awid = 4'd5; s_io_awlen = 8'd3; s_io_awvalid = 1'b1;
        tick();
        s_io_awvalid = 1'b0;
        s_io_wdata = 8'hAB; s_io_wvalid = 1'b1;
        tick();
        s_io_wdata = 8'hCD;
        rx_push(8'h01); rx_push(8'h02); rx_push(8'h03);
        rst = 1'b1;
        #1;
        check("midrst_outs", all_outs(), 0);
        s_io_wvalid = 1'b0;
        tick();
        check("midrst_outs_hold", all_outs(), 0);
        rst = 1'b0;
        rx_q.delete();
        tx_ready = 1'b1;
        #1;
        read_burst(4'd4, 1'b1, 1);
        write_burst(4'd10, 3, 1'b0, 0);

        // Randomized mix of writes, RX traffic and reads.
        for (int it = 0; it < 10; it++) begin
            int k;
            write_burst(IDW'($urandom), $urandom_range(1, 6), 1'b1, 0);
            k = $urandom_range(0, DEPTH + 1);
            for (int j = 0; j < k; j++) rx_push(8'($urandom));
            if ($urandom_range(0, 2) == 0 || rx_q.size() == 0)
                read_burst(IDW'($urandom), 1'b1, $urandom_range(1, 3));
            else
                read_burst(IDW'($urandom), 1'b0, $urandom_range(1, rx_q.size()));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
